// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM:
// state codes, opcodes, ALUOp codes, datapath mux encodings.
// Optional feature macro: MIPS_CTRL_MEM_WAIT_EN (memory wait handshake).
package mips_ctrl_pkg;

  // FSM state codes (codes 12..15 are unused and recover to FETCH)
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  // Opcode field values (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // ALUOp codes understood by the ALU control unit
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Bundle of every datapath control produced by the decoder
  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // ALU operation for the immediate arithmetic/logic group
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bus between the main control FSM (master) and the
// multicycle datapath (slave).
// Optional feature macro: MIPS_CTRL_MEM_WAIT_EN (uses mem_ready).
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Output decoder of the main control FSM: maps the current state (plus
// the opcode latched in DECODE and the ALU zero flag) to datapath controls.
// Optional feature macro: MIPS_CTRL_MEM_WAIT_EN -- when defined, the
// FETCH-cycle IR load and PC update are gated by mem_ready.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       zero,
`ifdef MIPS_CTRL_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output ctrl_t      ctrl
);

  logic pc_write;
  logic branch;

  // Per-state control decode; anything not set for a state stays 0
  always_comb begin
    ctrl     = '0;
    pc_write = 1'b0;
    branch   = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
`ifdef MIPS_CTRL_MEM_WAIT_EN
        ctrl.ir_write  = mem_ready;
        pc_write       = mem_ready;
`else
        ctrl.ir_write  = 1'b1;
        pc_write       = 1'b1;
`endif
      end
      S_DECODE: begin
        // branch target PC + (imm << 2) precomputed into ALUOut
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        branch         = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        pc_write       = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op(opcode);
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
    // bne takes the branch when the compare is non-zero, beq when zero
    ctrl.pc_en = pc_write | (branch & (zero ^ (opcode == OP_BNE)));
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore main control FSM for the multicycle MIPS datapath. Holds the
// state register, the opcode latched in DECODE and the sticky illegal_op
// flag; output decode lives in mips_ctrl_decode.
// Optional feature macro: MIPS_CTRL_MEM_WAIT_EN -- FETCH/MEM_RD/MEM_WR
// wait for mem_ready, aborting to FETCH after WAIT_TIMEOUT cycles.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 15
) (
  input logic                      clk,
  input logic                      rst,
  mips_multicycle_control_if.master bus
);

  state_t     state_reg, state_next;
  logic [5:0] opcode_reg, opcode_next;
  logic       illegal_reg, illegal_next;
  ctrl_t      ctrl;

`ifdef MIPS_CTRL_MEM_WAIT_EN
  logic [3:0] wait_cnt_reg, wait_cnt_next;
  logic       wait_state;

  // Wait counter: cleared on every state entry, counts stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt_reg <= 4'd0;
    else     wait_cnt_reg <= wait_cnt_next;
  end
`else
  // mem_ready and the timeout only matter with the wait handshake
  logic unused_inputs;
  assign unused_inputs = bus.mem_ready ^ (WAIT_TIMEOUT != 0);
`endif

  // State, latched opcode and sticky illegal flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      opcode_reg  <= 6'd0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      opcode_reg  <= opcode_next;
      illegal_reg <= illegal_next;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_next   = state_reg;
    opcode_next  = opcode_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        opcode_next = bus.opcode;
        case (bus.opcode)
          OP_LW, OP_SW:                      state_next = S_MEM_ADDR;
          OP_RTYPE:                          state_next = S_R_EXEC;
          OP_BEQ, OP_BNE:                    state_next = S_BRANCH;
          OP_J:                              state_next = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_I_EXEC;
          default: begin
            state_next   = S_FETCH;
            illegal_next = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode_reg == OP_LW)      state_next = S_MEM_RD;
        else if (opcode_reg == OP_SW) state_next = S_MEM_WR;
        else                          state_next = S_FETCH;
      end
      S_MEM_RD: state_next = S_MEM_WB;
      S_MEM_WB: state_next = S_FETCH;
      S_MEM_WR: state_next = S_FETCH;
      S_R_EXEC: state_next = S_R_WB;
      S_R_WB:   state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_I_EXEC: state_next = S_I_WB;
      S_I_WB:   state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
`ifdef MIPS_CTRL_MEM_WAIT_EN
    // Memory states stall until mem_ready; a stall that lasts
    // WAIT_TIMEOUT cycles abandons the instruction and flags it
    wait_state    = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                    (state_reg == S_MEM_WR);
    wait_cnt_next = 4'd0;
    if (wait_state && !bus.mem_ready) begin
      if (wait_cnt_reg == 4'(WAIT_TIMEOUT - 1)) begin
        state_next   = S_FETCH;
        illegal_next = 1'b1;
      end else begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg + 4'd1;
      end
    end
`endif
  end

  mips_ctrl_decode u_decode (
    .state     (state_reg),
    .opcode    (opcode_reg),
    .zero      (bus.zero),
`ifdef MIPS_CTRL_MEM_WAIT_EN
    .mem_ready (bus.mem_ready),
`endif
    .ctrl      (ctrl)
  );

  assign bus.pc_en      = ctrl.pc_en;
  assign bus.i_or_d     = ctrl.i_or_d;
  assign bus.mem_read   = ctrl.mem_read;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.pc_source  = ctrl.pc_source;
  assign bus.illegal_op = illegal_reg;
  assign bus.state      = state_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control. The stimulus process
// pushes the expected state/controls for each cycle; a monitor pops and
// compares on the falling clock edge.
// Optional feature macro: MIPS_CTRL_MEM_WAIT_EN (adds wait/timeout cases).
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_multicycle_control_if bus ();

  mips_multicycle_control #(.WAIT_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  st;
    logic [15:0] vec;
    logic        ill;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  logic exp_ill = 1'b0;

  typedef int seq_t[6];

  // {pc_en,i_or_d,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,
  //  reg_write,alu_src_a,alu_src_b[1:0],alu_op[2:0],pc_source[1:0]}
  function automatic logic [15:0] pk(input logic pe, input logic iod,
      input logic mr, input logic mw, input logic irw, input logic rd,
      input logic m2r, input logic rw, input logic sa, input logic [1:0] sb,
      input logic [2:0] op, input logic [1:0] ps);
    return {pe, iod, mr, mw, irw, rd, m2r, rw, sa, sb, op, ps};
  endfunction

  // Expected controls, hand-written from the state table
  function automatic logic [15:0] exp_vec(input int st, input logic [5:0] op,
      input logic z, input logic rdy);
    logic [2:0] iop;
    case (op)
      6'b001100: iop = 3'b011;
      6'b001101: iop = 3'b100;
      6'b001010: iop = 3'b101;
      default:   iop = 3'b000;
    endcase
    case (st)
      0:  return pk(rdy,0,1,0,rdy,0,0,0,0,2'b01,3'b000,2'b00);
      1:  return pk(0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00);
      2:  return pk(0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00);
      3:  return pk(0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00);
      4:  return pk(0,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00);
      5:  return pk(0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00);
      6:  return pk(0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00);
      7:  return pk(0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00);
      8:  return pk(z ^ (op == 6'b000101),0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01);
      9:  return pk(1,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10);
      10: return pk(0,0,0,0,0,0,0,0,1,2'b10,iop,2'b00);
      11: return pk(0,0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic expect_state(input int st, input string tag);
    exp_t e;
    e.st  = 4'(st);
    e.vec = exp_vec(st, bus.opcode, bus.zero, bus.mem_ready);
    e.ill = exp_ill;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int n,
                           input seq_t sts, input string tag);
    bus.opcode = op;
    bus.zero   = z;
    for (int i = 0; i < n; i++) begin
      expect_state(sts[i], tag);
      step();
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] got;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = {bus.pc_en, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
             bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
             bus.alu_src_b, bus.alu_op, bus.pc_source};
      checks = checks + 3;
      if (bus.state !== e.st) begin
        errors++;
        $display("FAIL %s state: got %0d expected %0d", e.tag, bus.state, e.st);
      end
      if (got !== e.vec) begin
        errors++;
        $display("FAIL %s ctrl: got %b expected %b", e.tag, got, e.vec);
      end
      if (bus.illegal_op !== e.ill) begin
        errors++;
        $display("FAIL %s illegal_op: got %b expected %b", e.tag, bus.illegal_op, e.ill);
      end
      $display("txn %-12s state=%0d ctrl=%b illegal=%b", e.tag, bus.state, got, bus.illegal_op);
    end
  end

  initial begin
    rst           = 1'b1;
    bus.opcode    = 6'b100011;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    // two cycles in reset, then release with lw
    step(); expect_state(0, "reset");
    step(); expect_state(0, "reset");
    step(); rst = 1'b0;

    run_instr(6'b100011, 1'b0, 5, '{0,1,2,3,4,0}, "lw");
    run_instr(6'b000000, 1'b0, 4, '{0,1,6,7,0,0}, "rtype");
    run_instr(6'b101011, 1'b0, 4, '{0,1,2,5,0,0}, "sw");
    run_instr(6'b000101, 1'b0, 3, '{0,1,8,0,0,0}, "bne_z0");
    run_instr(6'b000101, 1'b1, 3, '{0,1,8,0,0,0}, "bne_z1");
    run_instr(6'b000100, 1'b1, 3, '{0,1,8,0,0,0}, "beq_z1");
    run_instr(6'b000100, 1'b0, 3, '{0,1,8,0,0,0}, "beq_z0");
    run_instr(6'b000010, 1'b0, 3, '{0,1,9,0,0,0}, "jump");
    run_instr(6'b001000, 1'b0, 4, '{0,1,10,11,0,0}, "addi");
    run_instr(6'b001100, 1'b0, 4, '{0,1,10,11,0,0}, "andi");
    run_instr(6'b001101, 1'b0, 4, '{0,1,10,11,0,0}, "ori");
    run_instr(6'b001010, 1'b0, 4, '{0,1,10,11,0,0}, "slti");

    // undefined opcode: back to FETCH, flag stays set through a lw
    run_instr(6'b111111, 1'b0, 2, '{0,1,0,0,0,0}, "illegal");
    exp_ill = 1'b1;
    run_instr(6'b100011, 1'b0, 5, '{0,1,2,3,4,0}, "lw_after_ill");

    // reset asserted inside MEM_WR aborts the store in that same cycle
    run_instr(6'b101011, 1'b0, 3, '{0,1,2,0,0,0}, "sw_pre_rst");
    rst     = 1'b1;
    exp_ill = 1'b0;
    expect_state(0, "rst_in_wr");
    step();
    rst = 1'b0;
    run_instr(6'b001000, 1'b0, 4, '{0,1,10,11,0,0}, "addi_post");

`ifdef MIPS_CTRL_MEM_WAIT_EN
    // FETCH stalls three cycles, then completes a lw
    bus.opcode    = 6'b100011;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_state(0, "wait_fetch");
      step();
    end
    bus.mem_ready = 1'b1;
    run_instr(6'b100011, 1'b0, 5, '{0,1,2,3,4,0}, "lw_wait");
    // mem_ready never arrives: abort after 15 stalled cycles
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      expect_state(0, "timeout");
      step();
    end
    exp_ill = 1'b1;
    expect_state(0, "timeout_abt");
    step();
    bus.mem_ready = 1'b1;
`endif

    step();
    step();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
